// File: rtl/psum_drain_acc_if.sv
// OFIFO drain port and output-memory stream port of the psum drain/accumulate block.
interface psum_drain_acc_if #(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8,
  parameter int unsigned addr_bw = 4
) ();
  localparam int unsigned vec_w = psum_bw * col;

  logic               ofifo_valid;
  logic [vec_w-1:0]   ofifo_data;
  logic               ofifo_rd;
  logic               out_valid;
  logic               out_ready;
  logic [vec_w-1:0]   out_data;
  logic [addr_bw-1:0] out_addr;

  modport master (
    output ofifo_valid, ofifo_data, out_ready,
    input  ofifo_rd, out_valid, out_data, out_addr
  );

  modport slave (
    input  ofifo_valid, ofifo_data, out_ready,
    output ofifo_rd, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/psum_drain_acc.sv
// Drains OFIFO psum vectors, accumulates them over several kernel passes with
// per-lane saturation, then streams the finished (optionally ReLU'd) vectors out.
module psum_drain_acc #(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8,
  parameter int unsigned depth   = 16,
  parameter int unsigned addr_bw = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_bw:0]    n_vec,
  input  logic [3:0]          num_pass,
  input  logic                en_relu,
  psum_drain_acc_if.slave     bus,
  output logic                busy,
  output logic                done
);
  localparam int unsigned vec_w = psum_bw * col;
  localparam int unsigned nv_w  = addr_bw + 1;

  typedef logic [vec_w-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, DRAIN, EMIT, DONE} state_t;

  state_t             state, state_nx;
  vec_t               acc_buf [depth];
  logic [addr_bw-1:0] vec_idx, emit_idx, emit_nxt, n_last, n_last_in;
  logic [3:0]         pass_idx, p_last, p_last_in;
  logic               relu_q;
  logic               last_pop;

  // Per-lane signed add clamped to the lane range.
  function automatic vec_t sat_add(vec_t a, vec_t b);
    vec_t r;
    logic signed [psum_bw:0] s;
    r = '0;
    for (int unsigned k = 0; k < col; k++) begin
      s = $signed({a[k*psum_bw+psum_bw-1], a[k*psum_bw +: psum_bw]})
        + $signed({b[k*psum_bw+psum_bw-1], b[k*psum_bw +: psum_bw]});
      if (s[psum_bw] != s[psum_bw-1])
        r[k*psum_bw +: psum_bw] = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                             : {1'b0, {(psum_bw-1){1'b1}}};
      else
        r[k*psum_bw +: psum_bw] = s[psum_bw-1:0];
    end
    return r;
  endfunction

  function automatic vec_t relu(vec_t v, logic en);
    vec_t r;
    r = v;
    for (int unsigned k = 0; k < col; k++)
      if (en && v[k*psum_bw+psum_bw-1]) r[k*psum_bw +: psum_bw] = '0;
    return r;
  endfunction

  // Clamp the requested tile shape into what the buffer can hold.
  always_comb begin
    if (n_vec == '0)              n_last_in = '0;
    else if (n_vec > nv_w'(depth)) n_last_in = addr_bw'(depth - 1);
    else                          n_last_in = addr_bw'(n_vec - nv_w'(1));
    p_last_in = (num_pass == 4'd0) ? 4'd0 : num_pass - 4'd1;
  end

  assign last_pop = (vec_idx == n_last) && (pass_idx == p_last);
  assign emit_nxt = emit_idx + addr_bw'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.ofifo_rd = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = DRAIN;
      DRAIN: begin
        bus.ofifo_rd = bus.ofifo_valid;
        if (bus.ofifo_valid && last_pop) state_nx = EMIT;
      end
      EMIT:  if (bus.out_valid && bus.out_ready && emit_idx == n_last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control counters and the registered output stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      vec_idx       <= '0;
      pass_idx      <= '0;
      emit_idx      <= '0;
      n_last        <= '0;
      p_last        <= '0;
      relu_q        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);
      if (state == IDLE && start) begin
        n_last   <= n_last_in;
        p_last   <= p_last_in;
        relu_q   <= en_relu;
        vec_idx  <= '0;
        pass_idx <= '0;
        emit_idx <= '0;
      end
      if (bus.ofifo_rd) begin
        if (vec_idx == n_last) begin
          vec_idx  <= '0;
          pass_idx <= pass_idx + 4'd1;
        end else begin
          vec_idx  <= vec_idx + addr_bw'(1);
        end
      end
      if (state == EMIT) begin
        if (!bus.out_valid) begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= relu(acc_buf[emit_idx], relu_q);
          bus.out_addr  <= emit_idx;
        end else if (bus.out_ready) begin
          if (emit_idx == n_last) begin
            bus.out_valid <= 1'b0;
          end else begin
            emit_idx     <= emit_nxt;
            bus.out_data <= relu(acc_buf[emit_nxt], relu_q);
            bus.out_addr <= emit_nxt;
          end
        end
      end
    end
  end

  // Accumulation buffer; pass 0 overwrites so stale contents never leak in.
  always_ff @(posedge clk) begin
    if (bus.ofifo_rd)
      acc_buf[vec_idx] <= (pass_idx == 4'd0) ? bus.ofifo_data
                                             : sat_add(acc_buf[vec_idx], bus.ofifo_data);
  end
endmodule

// File: tb/tb_psum_drain_acc.sv
// Scoreboard bench for psum_drain_acc: OFIFO/ready driver, output monitor, directed tiles.
module tb_psum_drain_acc;
  localparam int unsigned PB    = 16;
  localparam int unsigned COL   = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AB    = 4;
  localparam int unsigned VW    = PB * COL;

  typedef logic [VW-1:0] vec_t;
  typedef struct packed {
    logic [AB-1:0] addr;
    vec_t          data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        en_relu = 1'b0;
  logic [AB:0] n_vec = '0;
  logic [3:0]  num_pass = '0;
  logic        busy, done;

  psum_drain_acc_if #(.psum_bw(PB), .col(COL), .addr_bw(AB)) bus ();

  psum_drain_acc #(.psum_bw(PB), .col(COL), .depth(DEPTH), .addr_bw(AB)) dut (
    .clk(clk), .reset(rst_n), .start(start), .n_vec(n_vec), .num_pass(num_pass),
    .en_relu(en_relu), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  vec_t  ofq[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    pops = 0;
  bit    gaps = 1'b0;
  bit    bp = 1'b0;

  task automatic chk(string name, vec_t act, vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t fill(int v);
    vec_t r;
    for (int unsigned k = 0; k < COL; k++) r[k*PB +: PB] = PB'(v);
    return r;
  endfunction

  // OFIFO model (show-ahead queue with optional gaps) and out_ready pattern driver.
  initial begin
    logic pop_now;
    logic pat [4];
    int   cyc;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    cyc = 0;
    bus.ofifo_valid = 1'b0;
    bus.ofifo_data  = '0;
    bus.out_ready   = 1'b1;
    forever begin
      @(negedge clk);
      pop_now = bus.ofifo_rd;
      @(posedge clk);
      #1;
      if (pop_now) begin
        if (ofq.size() > 0) void'(ofq.pop_front());
        pops++;
      end
      cyc++;
      bus.ofifo_valid = (ofq.size() > 0) && !(gaps && (cyc % 3 == 1));
      bus.ofifo_data  = (ofq.size() > 0) ? ofq[0] : '0;
      bus.out_ready   = bp ? pat[cyc % 4] : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stalled outputs hold.
  logic          prev_stall = 1'b0;
  vec_t          prev_data;
  logic [AB-1:0] prev_addr;
  exp_t          mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", vec_t'(bus.out_valid), vec_t'(1));
        chk("hold_data", bus.out_data, prev_data);
        chk("hold_addr", vec_t'(bus.out_addr), vec_t'(prev_addr));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got addr %0d data %h with nothing expected",
                   bus.out_addr, bus.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_addr", vec_t'(bus.out_addr), vec_t'(mon_e.addr));
          chk("out_data", bus.out_data, mon_e.data);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_addr  = bus.out_addr;
    end
  end

  task automatic expect_vec(int addr, vec_t data);
    exp_t e;
    e.addr = AB'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Runs one tile; config inputs are scrambled after start to prove they were latched.
  task automatic run_tile(int nv, int np, bit relu_en, int exp_pops, int exp_lat, bit start_in_emit);
    int cyc;
    bit got;
    bit sent;
    pops     = 0;
    n_vec    = (AB+1)'(nv);
    num_pass = 4'(np);
    en_relu  = relu_en;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_vec    = '0;
    num_pass = 4'd0;
    en_relu  = ~relu_en;
    cyc  = 1;
    got  = 1'b0;
    sent = 1'b0;
    while (cyc < 3000) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) chk("busy_run", vec_t'(busy), vec_t'(1));
      if (done) begin
        got = 1'b1;
        break;
      end
      if (start_in_emit && !sent && bus.out_valid) begin
        start    = 1'b1;
        n_vec    = (AB+1)'(1);
        num_pass = 4'd1;
        sent     = 1'b1;
      end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL tile_timeout: no done after %0d cycles", cyc);
    end else if (exp_lat > 0) begin
      chk("latency", vec_t'(cyc), vec_t'(exp_lat));
    end
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", vec_t'(done), vec_t'(0));
    chk("busy_idle", vec_t'(busy), vec_t'(0));
    chk("sb_empty", vec_t'(exp_q.size()), vec_t'(0));
    chk("pops", vec_t'(pops), vec_t'(exp_pops));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset held with OFIFO valid and start asserted.
    ofq.push_back(fill(1));
    start = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ofifo_rd", vec_t'(bus.ofifo_rd), vec_t'(0));
    chk("rst_out_valid", vec_t'(bus.out_valid), vec_t'(0));
    chk("rst_busy", vec_t'(busy), vec_t'(0));
    chk("rst_done", vec_t'(done), vec_t'(0));
    chk("rst_out_data", bus.out_data, vec_t'(0));
    chk("rst_out_addr", vec_t'(bus.out_addr), vec_t'(0));
    @(posedge clk); #1;
    start = 1'b0;
    ofq.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single pass, four vectors; one extra vector must stay queued.
    for (int i = 0; i < 4; i++) begin
      ofq.push_back(fill(i));
      expect_vec(i, fill(i));
    end
    ofq.push_back(fill(77));
    run_tile(4, 1, 1'b0, 4, 10, 1'b0);
    chk("leftover_single", vec_t'(ofq.size()), vec_t'(1));
    ofq.delete();
    repeat (2) @(posedge clk);

    // Three-pass accumulation: 5 - 2 + 10 = 13.
    ofq.push_back(fill(5));  ofq.push_back(fill(5));
    ofq.push_back(fill(-2)); ofq.push_back(fill(-2));
    ofq.push_back(fill(10)); ofq.push_back(fill(10));
    expect_vec(0, fill(13));
    expect_vec(1, fill(13));
    run_tile(2, 3, 1'b0, 6, 0, 1'b0);

    // Saturation with ReLU: positive clamps high, negative clamps then zeroes.
    ofq.push_back(fill(30000)); ofq.push_back(fill(-30000));
    ofq.push_back(fill(30000)); ofq.push_back(fill(-30000));
    expect_vec(0, fill(32767));
    expect_vec(1, fill(0));
    run_tile(2, 2, 1'b1, 4, 0, 1'b0);

    // Negative saturation without ReLU.
    ofq.push_back(fill(-30000)); ofq.push_back(fill(-30000));
    expect_vec(0, fill(-32768));
    run_tile(1, 2, 1'b0, 2, 0, 1'b0);

    // Backpressure on the output plus gaps on the OFIFO side.
    gaps = 1'b1;
    bp   = 1'b1;
    ofq.push_back(fill(1));  ofq.push_back(fill(2));  ofq.push_back(fill(3));
    ofq.push_back(fill(10)); ofq.push_back(fill(20)); ofq.push_back(fill(30));
    expect_vec(0, fill(11));
    expect_vec(1, fill(22));
    expect_vec(2, fill(33));
    run_tile(3, 2, 1'b0, 6, 0, 1'b0);
    gaps = 1'b0;
    bp   = 1'b0;

    // n_vec=0 and num_pass=0 both act as 1.
    ofq.push_back(fill(42));
    ofq.push_back(fill(99));
    expect_vec(0, fill(42));
    run_tile(0, 0, 1'b0, 1, 0, 1'b0);
    chk("leftover_nvec0", vec_t'(ofq.size()), vec_t'(1));
    ofq.delete();
    repeat (2) @(posedge clk);

    // n_vec beyond depth clamps to depth; start pulsed during EMIT is ignored.
    bp = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ofq.push_back(fill(i * 3 - 20));
      expect_vec(i, fill(i * 3 - 20));
    end
    run_tile(19, 1, 1'b0, 16, 0, 1'b1);
    bp = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_after_emit_start", vec_t'(busy), vec_t'(0));

    // Reset in the middle of DRAIN, then a fresh tile must not see old state.
    ofq.push_back(fill(100));
    n_vec    = (AB+1)'(2);
    num_pass = 4'd2;
    en_relu  = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    ofq.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("busy_after_reset", vec_t'(busy), vec_t'(0));
    ofq.push_back(fill(7));
    ofq.push_back(fill(8));
    expect_vec(0, fill(7));
    expect_vec(1, fill(8));
    run_tile(2, 1, 1'b0, 2, 0, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
